// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : muldiv_pkg
// Shared operation/state encodings and helpers for the iterative mul/div unit.
// Rev    : 1.0
// ============================================================================
package muldiv_pkg;

   // Widest value neg_if handles; callers cast in and out at their own width.
   localparam int c_MAX_W = 128;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   // Low bits of a two's-complement negation depend only on low bits, so a
   // narrower caller can truncate the result safely.
   function automatic logic [c_MAX_W-1:0] neg_if(input logic [c_MAX_W-1:0] value,
                                                 input logic               cond);
      return cond ? -value : value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_step.sv
`default_nettype none
// ============================================================================
// Module : muldiv_step
// One iteration of shift-add multiply or restoring shift-subtract divide.
// Rev    : 1.0
// ============================================================================
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 i_isDiv,
   input  logic [2*WIDTH-1:0]   i_accIn,
   input  logic [WIDTH-1:0]     i_operand,
   output logic [2*WIDTH-1:0]   o_accOut
);

   logic [WIDTH:0] w_mulSum;
   logic [WIDTH:0] w_divTrial;
   logic [WIDTH:0] w_divDiff;

   // Multiply: accumulator is {partial product, remaining multiplier bits}.
   assign w_mulSum   = {1'b0, i_accIn[2*WIDTH-1:WIDTH]}
                     + {1'b0, (i_accIn[0] ? i_operand : {WIDTH{1'b0}})};
   // Divide: accumulator is {partial remainder, dividend/quotient bits}.
   assign w_divTrial = i_accIn[2*WIDTH-1:WIDTH-1];
   assign w_divDiff  = w_divTrial - {1'b0, i_operand};

   always_comb begin
      o_accOut = {w_mulSum, i_accIn[WIDTH-1:1]};
      if (i_isDiv) begin
         if (!w_divDiff[WIDTH]) begin
            o_accOut = {w_divDiff[WIDTH-1:0], i_accIn[WIDTH-2:0], 1'b1};
         end else begin
            o_accOut = {w_divTrial[WIDTH-1:0], i_accIn[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and stall request.
// Rev    : 1.0
// ============================================================================
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic              flush,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              busy,
   output logic              stall,
   output logic              done,
   output logic [WIDTH-1:0]  hi,
   output logic [WIDTH-1:0]  lo,
   output logic              div_by_zero
);

   localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH-1);

   state_e               r_state;
   state_e               w_nextState;
   logic                 w_accept;
   op_e                  r_op;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic                 r_sa;
   logic                 r_sb;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_opnd;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_dbz;

   logic                 w_isDiv;
   logic                 w_isSigned;
   logic                 w_negA;
   logic                 w_negB;
   logic [WIDTH-1:0]     w_magA;
   logic [WIDTH-1:0]     w_magB;
   logic [2*WIDTH-1:0]   w_stepAcc;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quot;
   logic [WIDTH-1:0]     w_rem;
   logic                 w_divZero;

   assign w_isDiv    = r_op[1];
   assign w_isSigned = ~r_op[0];
   assign w_negA     = w_isSigned & r_a[WIDTH-1];
   assign w_negB     = w_isSigned & r_b[WIDTH-1];
   assign w_magA     = WIDTH'(neg_if(c_MAX_W'(r_a), w_negA));
   assign w_magB     = WIDTH'(neg_if(c_MAX_W'(r_b), w_negB));
   assign w_divZero  = (r_b == {WIDTH{1'b0}});

   // Sign correction; the most-negative / -1 case wraps naturally here.
   assign w_prod = (2*WIDTH)'(neg_if(c_MAX_W'(r_acc), r_sa ^ r_sb));
   assign w_quot = WIDTH'(neg_if(c_MAX_W'(r_acc[WIDTH-1:0]), r_sa ^ r_sb));
   assign w_rem  = WIDTH'(neg_if(c_MAX_W'(r_acc[2*WIDTH-1:WIDTH]), r_sa));

   muldiv_step #(
      .WIDTH     (WIDTH)
   ) u_step (
      .i_isDiv   (w_isDiv),
      .i_accIn   (r_acc),
      .i_operand (r_opnd),
      .o_accOut  (w_stepAcc)
   );

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_nextState = S_IDLE;
            if (start && !flush) begin
               w_accept    = 1'b1;
               w_nextState = S_PREP;
            end
         end
         S_PREP:  w_nextState = flush ? S_IDLE : S_RUN;
         S_RUN: begin
            if (flush) begin
               w_nextState = S_IDLE;
            end else if (r_cnt == c_LAST_CNT) begin
               w_nextState = S_FIX;
            end
         end
         S_FIX:   w_nextState = flush ? S_IDLE : S_DONE;
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_op    <= OP_MULT;
         r_a     <= '0;
         r_b     <= '0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_acc   <= '0;
         r_opnd  <= '0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_dbz   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_op <= op_e'(op);
            r_a  <= a;
            r_b  <= b;
         end
         case (r_state)
            S_PREP: begin
               r_sa   <= w_negA;
               r_sb   <= w_negB;
               // Low half seeds the multiplier (mul) or dividend (div).
               r_acc  <= {{WIDTH{1'b0}}, (w_isDiv ? w_magA : w_magB)};
               r_opnd <= w_isDiv ? w_magB : w_magA;
               r_cnt  <= '0;
            end
            S_RUN: begin
               r_acc <= w_stepAcc;
               r_cnt <= r_cnt + CNT_W'(1);
            end
            S_FIX: begin
               if (!flush) begin
                  r_dbz <= w_isDiv & w_divZero;
                  if (!w_isDiv) begin
                     {r_hi, r_lo} <= w_prod;
                  end else if (w_divZero) begin
                     r_hi <= r_a;
                     r_lo <= {WIDTH{1'b1}};
                  end else begin
                     r_hi <= w_rem;
                     r_lo <= w_quot;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state == S_PREP) | (r_state == S_RUN) | (r_state == S_FIX);
   assign done        = (r_state == S_DONE);
   assign stall       = busy | (start & ((r_state == S_IDLE) | (r_state == S_DONE)));
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign div_by_zero = r_dbz & done;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_muldiv_unit
// Directed scoreboard bench for ex_muldiv_unit at WIDTH=32.
// Rev    : 1.0
// ============================================================================
module tb_ex_muldiv_unit;

   localparam int c_W   = 32;
   localparam int c_LAT = c_W + 3;

   typedef struct {
      logic [c_W-1:0] hi;
      logic [c_W-1:0] lo;
      logic           dbz;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [1:0]     op = 2'b00;
   logic           flush = 1'b0;
   logic [c_W-1:0] a = '0;
   logic [c_W-1:0] b = '0;
   logic           busy, stall, done, div_by_zero;
   logic [c_W-1:0] hi, lo;

   int   nTests = 0;
   int   nFail  = 0;
   int   cycleCnt = 0;
   int   tStart = 0;
   exp_t sbq[$];

   ex_muldiv_unit #(.WIDTH(c_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .flush       (flush),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .stall       (stall),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expectRes(input logic [c_W-1:0] eh, input logic [c_W-1:0] el, input logic ed);
      exp_t e;
      e.hi = eh; e.lo = el; e.dbz = ed;
      sbq.push_back(e);
   endtask

   // Called at a negedge: drives start for one cycle, leaves the bench in cycle 1.
   task automatic issue(input logic [1:0] o, input logic [c_W-1:0] aa, input logic [c_W-1:0] bb);
      start = 1'b1; op = o; a = aa; b = bb;
      tStart = cycleCnt;
      #1 check("stall_on_start", stall, 1);
      @(negedge clk);
      start = 1'b0;
      check("busy_cycle1", busy, 1);
   endtask

   // Waits for the done pulse, then pops the scoreboard and compares.
   task automatic waitDone();
      bit   seen = 0;
      bit   stallGap = 0;
      exp_t e;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1;
         else if (stall !== 1'b1) stallGap = 1;
      end
      check("done_seen", seen, 1);
      check("stall_held", stallGap, 0);
      if (seen) begin
         check("latency", cycleCnt - tStart, c_LAT);
         check("busy_in_done", busy, 0);
         check("sb_nonempty", sbq.size() > 0, 1);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            check("div_by_zero", div_by_zero, e.dbz);
         end
      end
   endtask

   initial begin
      bit doneSeen;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_dbz", div_by_zero, 0);
      rst = 1'b1;
      @(negedge clk);

      // Basic signed/unsigned multiply and divide, plus divide boundaries.
      expectRes(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      issue(2'b00, 32'hFFFFFFFF, 32'h2);  waitDone();
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("hi_held", hi, 32'hFFFFFFFF);
      expectRes(32'h1, 32'hFFFFFFFE, 1'b0);
      issue(2'b01, 32'hFFFFFFFF, 32'h2);  waitDone(); @(negedge clk);
      expectRes(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      issue(2'b10, 32'hFFFFFFF9, 32'h2);  waitDone(); @(negedge clk);
      expectRes(32'd2, 32'd14, 1'b0);
      issue(2'b11, 32'd100, 32'd7);       waitDone(); @(negedge clk);
      expectRes(32'h64, 32'hFFFFFFFF, 1'b1);
      issue(2'b11, 32'h64, 32'h0);        waitDone(); @(negedge clk);
      check("dbz_cleared", div_by_zero, 0);
      expectRes(32'h0, 32'h80000000, 1'b0);
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF); waitDone(); @(negedge clk);

      // Start while busy is ignored; a start in the done cycle is accepted.
      expectRes(32'h0, 32'd15, 1'b0);
      issue(2'b00, 32'd3, 32'd5);
      repeat (9) @(negedge clk);
      start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd4;
      #1 check("stall_busy_start", stall, 1);
      @(negedge clk);
      start = 1'b0;
      waitDone();
      expectRes(32'd2, 32'd14, 1'b0);
      issue(2'b11, 32'd100, 32'd7);
      waitDone(); @(negedge clk);
      check("stall_after_done", stall, 0);

      // Flush mid-operation keeps the old HI/LO.
      expectRes(32'h1234, 32'h5678, 1'b0);
      issue(2'b11, 32'h56781234, 32'h00010000); waitDone(); @(negedge clk);
      issue(2'b01, 32'd6, 32'd7);
      repeat (11) @(negedge clk);
      check("busy_before_flush", busy, 1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_stall", stall, 0);
      doneSeen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done !== 1'b0) doneSeen = 1;
      end
      check("flush_no_done", doneSeen, 0);
      check("flush_hi", hi, 32'h1234);
      check("flush_lo", lo, 32'h5678);

      // Flush with start in IDLE drops the start.
      start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start_dropped", busy, 0);

      // Reset mid-divide, then a normal operation after release.
      issue(2'b10, 32'hFFFFFF9C, 32'd7);
      repeat (19) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_stall", stall, 0);
      check("midrst_hi", hi, 0);
      check("midrst_lo", lo, 0);
      rst = 1'b1;
      @(negedge clk);
      expectRes(32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);
      issue(2'b10, 32'hFFFFFF9C, 32'd7);  waitDone(); @(negedge clk);

      check("sb_drained", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit that sits beside the ALU in the EX stage of the 5-stage pipeline. It executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the results in architectural HI/LO registers. While an operation is in flight it raises a stall request to the hazard unit, which freezes PC, IF/ID and ID/EX. It is the first multi-cycle execute resource in the datapath; the single-cycle ALU has no equivalent.

Parameters:
WIDTH, 32, operand/HI/LO width in bits; must be even and at least 4
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active low; state cleared on a rising edge while rst==0
start  input  1  request from EX stage to begin an operation
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
flush  input  1  abort the in-flight operation, e.g. on branch mispredict or exception
a  input  WIDTH  operand A from the forwarding mux; multiplicand or dividend
b  input  WIDTH  operand B from the forwarding mux; multiplier or divisor
busy  output  1  operation in flight (PREP/RUN/FIX)
stall  output  1  combinational stall request to the hazard unit
done  output  1  one-cycle pulse; HI/LO hold the new result
hi  output  WIDTH  HI register: product upper half, or remainder
lo  output  WIDTH  LO register: product lower half, or quotient
div_by_zero  output  1  valid while done==1; the completed DIV/DIVU had b==0

Behaviour:
- Reset (rst==0 at an edge): state returns to IDLE. hi, lo, busy, done and div_by_zero all go to 0. Reset overrides start and flush and aborts any operation mid-flight.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: when start==1, latch op, a and b, then go to PREP.
- DONE: lasts one cycle with done==1. If start==1 in this cycle it is accepted exactly as in IDLE (back-to-back operations); otherwise go to IDLE.
- PREP (1 cycle): record sign flags sa = a[MSB] and sb = b[MSB], applied only for signed ops. Convert operands to WIDTH-bit unsigned magnitudes. The magnitude of the most-negative value, 2^(WIDTH-1), fits. Clear the 2*WIDTH accumulator and set the counter to 0. Go to RUN.
- RUN: exactly WIDTH cycles, one bit per cycle. The counter goes 0..WIDTH-1; on counter==WIDTH-1 go to FIX.
  - Multiply: shift-add, using the multiplier LSB each cycle.
  - Divide: restoring shift-subtract, producing a WIDTH-bit quotient and remainder.
- FIX (1 cycle): write hi/lo and go to DONE.
  - Multiply: negate the 2*WIDTH product when sa^sb (signed op only). {hi,lo} = product.
  - Divide: negate the quotient when sa^sb, and the remainder when sa (signed op only). lo = quotient, hi = remainder.
  - Divide by zero (b==0): the result is overridden to lo = all ones, hi = a (original dividend), and div_by_zero is flagged.
  - DIV of the most-negative value by -1: lo = most-negative value (wrap), hi = 0.
- Latency is fixed and data-independent, including divide by zero. With start accepted in cycle 0:
  - busy==1 in cycles 1..WIDTH+2;
  - done==1 in cycle WIDTH+3 (cycle 35 when WIDTH==32);
  - hi/lo carry the new value from cycle WIDTH+3 onward.
- stall = busy | (start & (state==IDLE | state==DONE)). It is low in the done cycle unless a new start is accepted there.
- start while busy: ignored. No queueing, and operands are not re-latched.
- flush: in PREP, RUN or FIX, go to IDLE at the next edge. hi/lo keep their old values and done never pulses.
  - flush with start in IDLE/DONE in the same cycle: the start is dropped.
  - flush in DONE: done is already visible this cycle, and the committed hi/lo stay.
- hi/lo change only in FIX and on reset. They are held indefinitely otherwise, for later MFHI/MFLO reads.

Decomposition:
- Package muldiv_pkg holds:
  - op_e (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state_e (S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE);
  - helper function neg_if(value, cond), two's-complement negate.
- One natural sub-module, muldiv_step: the combinational per-iteration datapath (shift-add or shift-subtract of accumulator and divisor). The FSM, counter, sign flags and HI/LO stay in ex_muldiv_unit.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFF b=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse in cycle 35; MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=14, hi=2.
- DIVU a=0x64 b=0 -> lo=0xFFFFFFFF, hi=0x64, div_by_zero=1 in the done cycle (cycle 35); DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT a=3 b=5 accepted, then start pulsed with new operands in cycle 10 -> ignored, result hi=0 lo=15; next start in the done cycle is accepted and stall stays high continuously.
- Start MULTU 6*7 with prior hi/lo=0x1234/0x5678, flush in cycle 12 -> busy falls in cycle 13, no done pulse, hi/lo remain 0x1234/0x5678, stall==0 in cycle 13.
- Drive rst=0 at cycle 20 of a DIV -> next cycle busy=done=stall=0 and hi=lo=0; a start after release completes normally, 35 cycles later.
